// File: rtl/id_stage.sv
// id_stage: MIPS-style instruction decode stage.
// Holds one instruction from IF, decodes register addresses, the extended
// immediate and the destination register, resolves branches/jumps and
// redirects IF, and counts cycles spent holding a valid instruction under stall.
// Ports:
//   clk, resetn                : clock, async active-low reset
//   stallD, es_allowin         : hazard stall, EXE back-pressure
//   fs_to_ds_valid/bus         : instruction {inst, pc} from IF
//   ds_allowin, br_bus         : handshake and {taken, target} redirect to IF
//   rf_raddr1/2, rf_rdata1/2   : register file read port (rs, rt)
//   ds_to_es_valid/bus         : decoded instruction to EXE
//   ds_stall_cnt               : saturating stall cycle counter
module id_stage (
    input  logic         clk,
    input  logic         resetn,
    input  logic         stallD,
    input  logic         es_allowin,
    input  logic         fs_to_ds_valid,
    input  logic [63:0]  fs_to_ds_bus,
    output logic         ds_allowin,
    output logic [32:0]  br_bus,
    output logic [4:0]   rf_raddr1,
    output logic [4:0]   rf_raddr2,
    input  logic [31:0]  rf_rdata1,
    input  logic [31:0]  rf_rdata2,
    output logic         ds_to_es_valid,
    output logic [164:0] ds_to_es_bus,
    output logic [31:0]  ds_stall_cnt
);

    localparam int unsigned XLEN      = 32;
    localparam int unsigned BR_BUS_WD = 32;
    localparam int unsigned FS_BUS_WD = 64;
    localparam int unsigned REG_AW    = 5;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_SLTIU   = 6'b001011;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] FN_JR      = 6'b001000;

    logic                 ds_valid_q, ds_valid_d;
    logic [FS_BUS_WD-1:0] ds_bus_q, ds_bus_d;
    logic [XLEN-1:0]      stall_cnt_q, stall_cnt_d;

    logic              ds_ready_go;
    logic [XLEN-1:0]   inst, pc, pc_plus4, br_off;
    logic [5:0]        op, funct;
    logic [15:0]       imm16;
    logic [XLEN-1:0]   imm_ext;
    logic [REG_AW-1:0] dest;
    logic              br_cond;
    logic [XLEN-1:0]   br_target;
    logic              br_taken;

    assign inst  = ds_bus_q[63:32];
    assign pc    = ds_bus_q[31:0];
    assign op    = inst[31:26];
    assign funct = inst[5:0];
    assign imm16 = inst[15:0];

    // Pipeline handshake
    assign ds_ready_go    = ~stallD;
    assign ds_allowin     = !ds_valid_q || (ds_ready_go && es_allowin);
    assign ds_to_es_valid = ds_valid_q && ds_ready_go;

    assign rf_raddr1 = inst[25:21];
    assign rf_raddr2 = inst[20:16];

    assign pc_plus4 = pc + XLEN'(4);
    assign br_off   = {{14{imm16[15]}}, imm16, 2'b00};

    // Immediate extension and destination selection
    always_comb begin
        imm_ext = {{16{imm16[15]}}, imm16};
        dest    = '0;
        case (op)
            OP_LUI:                   imm_ext = {imm16, 16'h0000};
            OP_ANDI, OP_ORI, OP_XORI: imm_ext = {16'h0000, imm16};
            default:                  ;
        endcase
        case (op)
            OP_JAL:     dest = REG_AW'(31);
            OP_SPECIAL: dest = (funct == FN_JR) ? '0 : inst[15:11];
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI,
            OP_ORI, OP_XORI, OP_LUI, OP_LW:
                        dest = inst[20:16];
            default:    dest = '0;
        endcase
    end

    // Branch condition and target
    always_comb begin
        br_cond   = 1'b0;
        br_target = '0;
        case (op)
            OP_BEQ: begin
                br_cond   = (rf_rdata1 == rf_rdata2);
                br_target = pc_plus4 + br_off;
            end
            OP_BNE: begin
                br_cond   = (rf_rdata1 != rf_rdata2);
                br_target = pc_plus4 + br_off;
            end
            OP_J, OP_JAL: begin
                br_cond   = 1'b1;
                br_target = {pc_plus4[31:28], inst[25:0], 2'b00};
            end
            OP_SPECIAL: begin
                br_cond   = (funct == FN_JR);
                br_target = rf_rdata1;
            end
            default: ;
        endcase
    end

    // Redirect only when the branch actually leaves ID this cycle
    assign br_taken = ds_valid_q && ds_ready_go && es_allowin && br_cond;
    assign br_bus   = {br_taken, br_taken ? br_target : BR_BUS_WD'(0)};

    assign ds_to_es_bus = {dest, imm_ext, rf_rdata2, rf_rdata1, inst, pc};
    assign ds_stall_cnt = stall_cnt_q;

    // Next-state for the ID latch and the saturating stall counter
    always_comb begin
        ds_valid_d  = ds_valid_q;
        ds_bus_d    = ds_bus_q;
        stall_cnt_d = stall_cnt_q;
        if (ds_allowin) begin
            ds_valid_d = fs_to_ds_valid;
            if (fs_to_ds_valid) begin
                ds_bus_d = fs_to_ds_bus;
            end
        end
        if (ds_valid_q && stallD && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + XLEN'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ds_valid_q  <= 1'b0;
            ds_bus_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            ds_valid_q  <= ds_valid_d;
            ds_bus_q    <= ds_bus_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed self-checking bench for id_stage with a behavioural
// reference model compared on every falling edge.
module tb_id_stage;

    logic         clk = 1'b0;
    logic         resetn;
    logic         stallD;
    logic         es_allowin;
    logic         fs_to_ds_valid;
    logic [63:0]  fs_to_ds_bus;
    logic         ds_allowin;
    logic [32:0]  br_bus;
    logic [4:0]   rf_raddr1, rf_raddr2;
    logic [31:0]  rf_rdata1, rf_rdata2;
    logic         ds_to_es_valid;
    logic [164:0] ds_to_es_bus;
    logic [31:0]  ds_stall_cnt;

    int checks = 0;
    int errors = 0;

    id_stage dut (
        .clk            (clk),
        .resetn         (resetn),
        .stallD         (stallD),
        .es_allowin     (es_allowin),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .ds_allowin     (ds_allowin),
        .br_bus         (br_bus),
        .rf_raddr1      (rf_raddr1),
        .rf_raddr2      (rf_raddr2),
        .rf_rdata1      (rf_rdata1),
        .rf_rdata2      (rf_rdata2),
        .ds_to_es_valid (ds_to_es_valid),
        .ds_to_es_bus   (ds_to_es_bus),
        .ds_stall_cnt   (ds_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [164:0] act, input logic [164:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_valid;
    logic [31:0] m_inst, m_pc, m_cnt;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid = 1'b0; m_inst = 32'h0; m_pc = 32'h0; m_cnt = 32'h0;
        end else begin
            if (m_valid && stallD && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (!m_valid || (!stallD && es_allowin)) begin
                m_valid = fs_to_ds_valid;
                if (fs_to_ds_valid) begin
                    m_inst = fs_to_ds_bus[63:32];
                    m_pc   = fs_to_ds_bus[31:0];
                end
            end
        end
    end

    function automatic logic [4:0] exp_dest(input logic [31:0] i);
        int op = int'(i[31:26]);
        if (op == 3) return 5'd31;
        if (op == 0) return (i[5:0] == 6'd8) ? 5'd0 : i[15:11];
        if (op inside {9, 10, 11, 12, 13, 14, 15, 35}) return i[20:16];
        return 5'd0;
    endfunction

    function automatic logic [31:0] exp_imm(input logic [31:0] i);
        int op = int'(i[31:26]);
        logic [31:0] u = {16'h0, i[15:0]};
        if (op == 15) return u * 65536;
        if (op inside {12, 13, 14}) return u;
        return 32'($signed(i[15:0]));
    endfunction

    function automatic logic [32:0] exp_br(input logic [31:0] i, input logic [31:0] p,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic go);
        int op = int'(i[31:26]);
        logic        t = 1'b0;
        logic [31:0] tgt = 32'h0;
        logic [31:0] off = 32'($signed(i[15:0])) * 4;
        logic [31:0] idx = {6'h0, i[25:0]};
        if (op == 4)      begin t = (a == b); tgt = p + 4 + off; end
        else if (op == 5) begin t = (a != b); tgt = p + 4 + off; end
        else if (op == 2 || op == 3) begin t = 1'b1; tgt = ((p + 4) & 32'hF000_0000) | (idx * 4); end
        else if (op == 0 && i[5:0] == 6'd8) begin t = 1'b1; tgt = a; end
        if (t && go) return {1'b1, tgt};
        return 33'h0;
    endfunction

    // Compare process: all outputs against the model every cycle
    always @(negedge clk) begin
        logic go;
        go = m_valid && !stallD && es_allowin;
        check("ds_allowin", 165'(ds_allowin), 165'(!m_valid || (!stallD && es_allowin)));
        check("ds_to_es_valid", 165'(ds_to_es_valid), 165'(m_valid && !stallD));
        check("ds_to_es_bus", ds_to_es_bus,
              {exp_dest(m_inst), exp_imm(m_inst), rf_rdata2, rf_rdata1, m_inst, m_pc});
        check("br_bus", 165'(br_bus), 165'(exp_br(m_inst, m_pc, rf_rdata1, rf_rdata2, go)));
        check("rf_raddr", 165'({rf_raddr1, rf_raddr2}), 165'({m_inst[25:21], m_inst[20:16]}));
        check("ds_stall_cnt", 165'(ds_stall_cnt), 165'(m_cnt));
    end

    // Accepted-by-EXE counter for the back-pressured jr
    localparam logic [31:0] JR_PC = 32'hBFC0_0050;
    int jr_accepts = 0;
    always @(posedge clk)
        if (resetn && ds_to_es_valid && es_allowin && ds_to_es_bus[31:0] == JR_PC) jr_accepts++;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic present(input logic [31:0] i, input logic [31:0] p);
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus   = {i, p};
    endtask

    logic [31:0] table_inst [10] = '{32'h3C01ABCD, 32'h3022F00F, 32'h38438001, 32'h2844FFFF,
                                    32'h8C45FFF0, 32'hAC460010, 32'h00432021, 32'h08000010,
                                    32'h14220003, 32'hFC000000};

    initial begin
        resetn = 1'b0; stallD = 1'b0; es_allowin = 1'b1;
        fs_to_ds_valid = 1'b0; fs_to_ds_bus = 64'h0;
        rf_rdata1 = 32'h0; rf_rdata2 = 32'h0;
        tick(); tick();
        check("rst_allowin", 165'(ds_allowin), 165'(1));
        check("rst_valid", 165'(ds_to_es_valid), 165'(0));
        check("rst_br_bus", 165'(br_bus), 165'(0));
        check("rst_bus", ds_to_es_bus, 165'(0));
        resetn = 1'b1;

        // addiu r2,r2,5
        present(32'h24420005, 32'hBFC00000); rf_rdata1 = 32'd10; rf_rdata2 = 32'd20;
        tick(); fs_to_ds_valid = 1'b0; #1;
        check("addiu_valid", 165'(ds_to_es_valid), 165'(1));
        check("addiu_dest", 165'(ds_to_es_bus[164:160]), 165'(2));
        check("addiu_imm", 165'(ds_to_es_bus[159:128]), 165'(32'h5));
        check("addiu_rs_val", 165'(ds_to_es_bus[95:64]), 165'(32'd10));
        tick();

        // beq taken backwards to itself
        present(32'h1022FFFF, 32'hBFC00010); rf_rdata1 = 32'd7; rf_rdata2 = 32'd7;
        tick(); fs_to_ds_valid = 1'b0; #1;
        check("beq_br_bus", 165'(br_bus), 165'(33'h1_BFC00010));
        tick();

        // jal
        present(32'h0C000100, 32'hBFC00020);
        tick(); fs_to_ds_valid = 1'b0; #1;
        check("jal_br_bus", 165'(br_bus), 165'(33'h1_B0000400));
        check("jal_dest", 165'(ds_to_es_bus[164:160]), 165'(31));
        tick();

        // taken bne held by stall for 3 cycles
        present(32'h14220004, 32'hBFC00030); rf_rdata1 = 32'd1; rf_rdata2 = 32'd2;
        tick(); stallD = 1'b1; present(32'h34431234, 32'hBFC00034); #1;
        check("stall_allowin", 165'(ds_allowin), 165'(0));
        check("stall_valid", 165'(ds_to_es_valid), 165'(0));
        check("stall_br_taken", 165'(br_bus[32]), 165'(0));
        check("stall_cnt0", 165'(ds_stall_cnt), 165'(0));
        tick(); tick(); tick(); #1;
        check("stall_cnt3", 165'(ds_stall_cnt), 165'(3));
        check("stall_bus_held", 165'(ds_to_es_bus[63:0]), 165'(64'h14220004_BFC00030));
        stallD = 1'b0;
        tick(); fs_to_ds_valid = 1'b0;
        tick();

        // jr back-pressured by EXE for 2 cycles
        present(32'h00A00008, JR_PC); rf_rdata1 = 32'h80001234;
        tick(); es_allowin = 1'b0; present(32'h24030009, 32'hBFC00054);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_valid", 165'(ds_to_es_valid), 165'(1));
            check("bp_pc", 165'(ds_to_es_bus[31:0]), 165'(JR_PC));
            check("bp_br_bus", 165'(br_bus), (c < 2) ? 165'(0) : 165'(33'h1_80001234));
            tick();
            if (c == 1) es_allowin = 1'b1;
        end
        fs_to_ds_valid = 1'b0;
        check("jr_accepts", 165'(jr_accepts), 165'(1));
        tick();

        // back-to-back mix of opcodes, checked by the model
        foreach (table_inst[k]) begin
            present(table_inst[k], 32'hBFC00060 + 32'(k * 4));
            rf_rdata1 = (k == 8) ? 32'h55 : $urandom;
            rf_rdata2 = (k == 8) ? 32'h55 : $urandom;
            tick();
        end
        fs_to_ds_valid = 1'b0;
        tick();

        // reset mid-cycle while a bne is taken
        present(32'h1422FFFC, 32'hBFC00100); rf_rdata1 = 32'd1; rf_rdata2 = 32'd2;
        stallD = 1'b1; tick(); tick(); stallD = 1'b0; fs_to_ds_valid = 1'b0; #1;
        check("rbne_taken", 165'(br_bus[32]), 165'(1));
        #1 resetn = 1'b0; #1;
        check("rbne_valid", 165'(ds_to_es_valid), 165'(0));
        check("rbne_br_bus", 165'(br_bus), 165'(0));
        check("rbne_cnt", 165'(ds_stall_cnt), 165'(0));
        check("rbne_allowin", 165'(ds_allowin), 165'(1));
        tick(); resetn = 1'b1;
        present(32'h24420005, 32'hBFC00200);
        tick(); fs_to_ds_valid = 1'b0; #1;
        check("post_rst_valid", 165'(ds_to_es_valid), 165'(1));
        check("post_rst_pc", 165'(ds_to_es_bus[31:0]), 165'(32'hBFC00200));
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
